// File: rtl/exc_pkg.sv
// Shared definitions for the commit-stage exception controller:
// ExcCode values, sequencer states and default vector layout.
package exc_pkg;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2
    } state_e;

    localparam logic [31:0] DEF_BEV_BASE = 32'hBFC0_0200;
    localparam logic [31:0] DEF_GEN_OFF  = 32'h0000_0180;
    localparam logic [31:0] DEF_INT_OFF  = 32'h0000_0200;

endpackage

// File: rtl/int_sync.sv
// Two-flop synchroniser for level-sensitive asynchronous request lines.
// Pulses shorter than two clocks may be missed.
module int_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q, meta_d;
    logic [W-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/exception_ctrl.sv
// Commit-stage exception/interrupt controller: prioritises the committing
// instruction's events, then sequences flush, CP0 strobes and fetch redirect.
module exception_ctrl
    import exc_pkg::*;
#(
    parameter int          N_HW_INT     = 6,
    parameter int          N_SW_INT     = 2,
    parameter int          FLUSH_CYCLES = 2,
    parameter logic [31:0] BEV_BASE     = DEF_BEV_BASE,
    parameter logic [31:0] GEN_OFF      = DEF_GEN_OFF,
    parameter logic [31:0] INT_OFF      = DEF_INT_OFF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ex_valid,
    input  logic [31:0]                  pc,
    input  logic                         in_ds,
    input  logic                         iaddr_err,
    input  logic                         ri,
    input  logic                         ov,
    input  logic                         sys,
    input  logic                         bp,
    input  logic                         eret,
    input  logic                         daddr_err,
    input  logic                         mem_we,
    input  logic [31:0]                  mem_vaddr,
    input  logic [N_HW_INT-1:0]          hw_int,
    input  logic [N_SW_INT-1:0]          sw_int,
    input  logic [N_HW_INT+N_SW_INT-1:0] int_mask,
    input  logic                         allow_int,
    input  logic [19:0]                  ebase,
    input  logic [31:0]                  epc_in,
    input  logic                         iv,
    input  logic                         bev,
    output logic [N_HW_INT+N_SW_INT-1:0] cause_ip,
    output logic                         busy,
    output logic                         flush,
    output logic                         cp0_wr_exp,
    output logic                         cp0_clean_exl,
    output logic                         cp0_badv_we,
    output logic [4:0]                   exp_code,
    output logic [31:0]                  exp_epc,
    output logic [31:0]                  exp_bad_vaddr,
    output logic                         redirect_valid,
    output logic [31:0]                  redirect_pc
);

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    logic [N_HW_INT-1:0] hw_sync;

    int_sync #(.W(N_HW_INT)) u_int_sync (
        .clk (clk),
        .rst (rst),
        .d   (hw_int),
        .q   (hw_sync)
    );

    assign cause_ip = {hw_sync, sw_int};

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [4:0]         code_q, code_d;
    logic [31:0]        epc_q, epc_d;
    logic [31:0]        badv_q, badv_d;
    logic [31:0]        target_q, target_d;
    logic               wr_exp_q, wr_exp_d;
    logic               clean_exl_q, clean_exl_d;
    logic               badv_we_q, badv_we_d;

    logic               int_req;
    logic               any_exc;
    logic [31:0]        vec_base;

    assign int_req  = allow_int & (|(cause_ip & int_mask));
    assign any_exc  = iaddr_err | ri | ov | sys | bp | daddr_err;
    assign vec_base = bev ? BEV_BASE : {ebase, 12'h000};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        code_d      = code_q;
        epc_d       = epc_q;
        badv_d      = badv_q;
        target_d    = target_q;
        wr_exp_d    = 1'b0;
        clean_exl_d = 1'b0;
        badv_we_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (ex_valid && (int_req || any_exc || eret)) begin
                    state_d     = FLUSH;
                    cnt_d       = CNT_W'(FLUSH_CYCLES - 1);
                    epc_d       = in_ds ? (pc - 32'd4) : pc;
                    wr_exp_d    = int_req | any_exc;
                    clean_exl_d = ~(int_req | any_exc);
                    target_d    = vec_base + ((int_req && iv) ? INT_OFF : GEN_OFF);
                    // Priority chain: interrupt first, eret only when nothing else fires.
                    if (int_req) begin
                        code_d = EXC_INT;
                    end else if (iaddr_err) begin
                        code_d    = EXC_ADEL;
                        badv_d    = pc;
                        badv_we_d = 1'b1;
                    end else if (ri) begin
                        code_d = EXC_RI;
                    end else if (ov) begin
                        code_d = EXC_OV;
                    end else if (sys) begin
                        code_d = EXC_SYS;
                    end else if (bp) begin
                        code_d = EXC_BP;
                    end else if (daddr_err) begin
                        code_d    = mem_we ? EXC_ADES : EXC_ADEL;
                        badv_d    = mem_vaddr;
                        badv_we_d = 1'b1;
                    end else begin
                        code_d   = 5'h00;
                        target_d = epc_in;
                    end
                end
            end
            FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = REDIRECT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            REDIRECT: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            code_q      <= '0;
            epc_q       <= '0;
            badv_q      <= '0;
            target_q    <= '0;
            wr_exp_q    <= 1'b0;
            clean_exl_q <= 1'b0;
            badv_we_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            code_q      <= code_d;
            epc_q       <= epc_d;
            badv_q      <= badv_d;
            target_q    <= target_d;
            wr_exp_q    <= wr_exp_d;
            clean_exl_q <= clean_exl_d;
            badv_we_q   <= badv_we_d;
        end
    end

    assign busy           = (state_q != IDLE);
    assign flush          = (state_q != IDLE);
    assign redirect_valid = (state_q == REDIRECT);
    assign redirect_pc    = target_q;
    assign cp0_wr_exp     = wr_exp_q;
    assign cp0_clean_exl  = clean_exl_q;
    assign cp0_badv_we    = badv_we_q;
    assign exp_code       = code_q;
    assign exp_epc        = epc_q;
    assign exp_bad_vaddr  = badv_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// Bench for exception_ctrl: directed scenarios followed by randomized
// transactions checked against a priority-table reference model.
module tb_exception_ctrl;

    localparam int F  = 2;
    localparam int NH = 6;
    localparam int NS = 2;
    localparam int NI = NH + NS;

    logic          clk = 1'b0;
    logic          rst;
    logic          ex_valid, in_ds, iaddr_err, ri, ov, sys, bp, eret, daddr_err, mem_we;
    logic [31:0]   pc, mem_vaddr, epc_in;
    logic [NH-1:0] hw_int;
    logic [NS-1:0] sw_int;
    logic [NI-1:0] int_mask;
    logic          allow_int, iv, bev;
    logic [19:0]   ebase;
    logic [NI-1:0] cause_ip;
    logic          busy, flush, cp0_wr_exp, cp0_clean_exl, cp0_badv_we, redirect_valid;
    logic [4:0]    exp_code;
    logic [31:0]   exp_epc, exp_bad_vaddr, redirect_pc;

    int checks   = 0;
    int failures = 0;

    exception_ctrl #(.N_HW_INT(NH), .N_SW_INT(NS), .FLUSH_CYCLES(F)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .pc(pc), .in_ds(in_ds),
        .iaddr_err(iaddr_err), .ri(ri), .ov(ov), .sys(sys), .bp(bp), .eret(eret),
        .daddr_err(daddr_err), .mem_we(mem_we), .mem_vaddr(mem_vaddr),
        .hw_int(hw_int), .sw_int(sw_int), .int_mask(int_mask), .allow_int(allow_int),
        .ebase(ebase), .epc_in(epc_in), .iv(iv), .bev(bev),
        .cause_ip(cause_ip), .busy(busy), .flush(flush), .cp0_wr_exp(cp0_wr_exp),
        .cp0_clean_exl(cp0_clean_exl), .cp0_badv_we(cp0_badv_we), .exp_code(exp_code),
        .exp_epc(exp_epc), .exp_bad_vaddr(exp_bad_vaddr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        bit        iaddr, ri, ov, sys, bp, daddr, eret, in_ds, mem_we, bev, iv, intr;
        bit [31:0] pc, vaddr, epc_in;
        bit [19:0] ebase;
    } txn_t;

    typedef struct {
        int        kind;      // 0 none, 1 exception/interrupt, 2 eret
        bit [4:0]  code;
        bit        badv_we;
        bit [31:0] epc, badv, target;
    } exp_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input txn_t t);
        exp_t      e;
        bit        f[6];
        int        c[6];
        bit [31:0] base;
        e.kind = 0; e.code = 0; e.badv_we = 0; e.badv = 0; e.target = 0;
        e.epc  = t.in_ds ? t.pc - 32'd4 : t.pc;
        base   = t.bev ? 32'hBFC00200 : {t.ebase, 12'h000};
        f = '{t.iaddr, t.ri, t.ov, t.sys, t.bp, t.daddr};
        c = '{4, 10, 12, 8, 9, (t.mem_we ? 5 : 4)};
        if (t.intr) begin
            e.kind = 1; e.code = 0;
            e.target = base + (t.iv ? 32'h200 : 32'h180);
            return e;
        end
        for (int i = 0; i < 6; i++) begin
            if (f[i]) begin
                e.kind = 1; e.code = 5'(c[i]);
                e.badv_we = (i == 0) || (i == 5);
                e.badv = (i == 0) ? t.pc : t.vaddr;
                e.target = base + 32'h180;
                return e;
            end
        end
        if (t.eret) begin
            e.kind = 2; e.target = t.epc_in;
        end
        return e;
    endfunction

    function automatic txn_t blank();
        txn_t t;
        t.iaddr = 0; t.ri = 0; t.ov = 0; t.sys = 0; t.bp = 0; t.daddr = 0; t.eret = 0;
        t.in_ds = 0; t.mem_we = 0; t.bev = 0; t.iv = 0; t.intr = 0;
        t.pc = 32'h0040_0000; t.vaddr = 0; t.epc_in = 0; t.ebase = 20'h80000;
        return t;
    endfunction

    task automatic drive(input txn_t t);
        pc = t.pc; in_ds = t.in_ds; iaddr_err = t.iaddr; ri = t.ri; ov = t.ov;
        sys = t.sys; bp = t.bp; eret = t.eret; daddr_err = t.daddr; mem_we = t.mem_we;
        mem_vaddr = t.vaddr; epc_in = t.epc_in; bev = t.bev; iv = t.iv; ebase = t.ebase;
    endtask

    // Issues one committing instruction; while busy, junk ex_valid traffic is
    // presented and must be ignored.
    task automatic run_txn(input string nm, input txn_t t, input bit junk);
        exp_t e;
        txn_t j;
        e = model(t);
        drive(t);
        ex_valid = 1'b1;
        step();
        if (junk) begin
            j = blank(); j.sys = 1'b1; j.pc = 32'hDEAD_BEE0; j.bev = ~t.bev;
            drive(j);
        end else begin
            ex_valid = 1'b0;
        end
        if (e.kind == 0) begin
            ex_valid = 1'b0;
            chk({nm, ".noev_flush"}, flush, 0);
            chk({nm, ".noev_busy"}, busy, 0);
            chk({nm, ".noev_wr"}, cp0_wr_exp, 0);
            chk({nm, ".noev_clr"}, cp0_clean_exl, 0);
            return;
        end
        chk({nm, ".t1_flush"}, flush, 1);
        chk({nm, ".t1_busy"}, busy, 1);
        chk({nm, ".t1_wr"}, cp0_wr_exp, (e.kind == 1));
        chk({nm, ".t1_clr"}, cp0_clean_exl, (e.kind == 2));
        chk({nm, ".t1_badvwe"}, cp0_badv_we, e.badv_we);
        chk({nm, ".t1_epc"}, exp_epc, e.epc);
        if (e.kind == 1) chk({nm, ".t1_code"}, exp_code, e.code);
        if (e.badv_we) chk({nm, ".t1_badv"}, exp_bad_vaddr, e.badv);
        chk({nm, ".t1_rv"}, redirect_valid, 0);
        for (int k = 2; k <= F; k++) begin
            step();
            chk({nm, ".fl_flush"}, flush, 1);
            chk({nm, ".fl_wr"}, cp0_wr_exp | cp0_clean_exl | cp0_badv_we, 0);
            chk({nm, ".fl_rv"}, redirect_valid, 0);
        end
        step();
        ex_valid = 1'b0;
        chk({nm, ".rd_rv"}, redirect_valid, 1);
        chk({nm, ".rd_flush"}, flush, 1);
        chk({nm, ".rd_pc"}, redirect_pc, e.target);
        if (e.kind == 1) chk({nm, ".rd_code_held"}, exp_code, e.code);
        step();
        chk({nm, ".end_busy"}, busy, 0);
        chk({nm, ".end_flush"}, flush, 0);
        chk({nm, ".end_rv"}, redirect_valid, 0);
    endtask

    txn_t t;
    bit   intr_now;

    initial begin
        rst = 1'b1; ex_valid = 0; hw_int = '0; sw_int = '0; int_mask = '0; allow_int = 0;
        t = blank(); drive(t);
        step(); step();
        chk("rst_busy", busy, 0);
        chk("rst_flush", flush, 0);
        chk("rst_wr", cp0_wr_exp, 0);
        chk("rst_rv", redirect_valid, 0);
        chk("rst_rpc", redirect_pc, 0);
        chk("rst_cause", cause_ip, 0);
        chk("rst_epc", exp_epc, 0);
        rst = 1'b0;
        step();

        // syscall with BEV vector
        t = blank(); t.bev = 1; t.sys = 1; t.pc = 32'hBFC00100;
        run_txn("sys_bev", t, 0);
        chk("sys_bev_target", redirect_pc, 32'hBFC00380);

        // interrupt through synchroniser, special vector
        hw_int = 6'b000001; allow_int = 1; int_mask = 8'h04;
        step();
        chk("sync_1clk", cause_ip[2], 0);
        step();
        chk("sync_2clk", cause_ip[2], 1);
        t = blank(); t.ebase = 20'h80000; t.iv = 1; t.intr = 1; t.sys = 1;
        run_txn("int", t, 0);
        chk("int_target", redirect_pc, 32'h80000200);
        hw_int = '0; step(); step(); step();

        // delay slot, overflow beats syscall
        t = blank(); t.in_ds = 1; t.pc = 32'h00400010; t.ov = 1; t.sys = 1;
        run_txn("ov_ds", t, 0);
        chk("ov_ds_epc", exp_epc, 32'h0040000C);
        chk("ov_ds_code", exp_code, 5'h0c);

        // data address errors
        t = blank(); t.daddr = 1; t.mem_we = 1; t.vaddr = 32'h1003;
        run_txn("ades", t, 0);
        t.mem_we = 0;
        run_txn("adel", t, 0);
        chk("adel_badv", exp_bad_vaddr, 32'h1003);

        // eret with junk ex_valid while busy
        t = blank(); t.eret = 1; t.epc_in = 32'h80001234;
        run_txn("eret", t, 1);
        chk("eret_target", redirect_pc, 32'h80001234);

        // eret loses to a coincident exception
        t = blank(); t.eret = 1; t.bp = 1; t.epc_in = 32'h1234_0000;
        run_txn("eret_bp", t, 0);

        // reset in FLUSH aborts immediately
        t = blank(); t.ri = 1; drive(t);
        ex_valid = 1; step(); ex_valid = 0;
        chk("abort_pre_flush", flush, 1);
        rst = 1; #1;
        chk("abort_flush", flush, 0);
        chk("abort_busy", busy, 0);
        step(); rst = 0;
        for (int k = 0; k < F + 2; k++) begin
            step();
            chk("abort_no_rv", redirect_valid, 0);
            chk("abort_no_flush", flush, 0);
        end

        // masked interrupt, no flags
        hw_int = 6'h3f; sw_int = 2'b11; int_mask = '0; allow_int = 1;
        step(); step(); step();
        t = blank();
        run_txn("masked", t, 0);

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            hw_int    = NH'($urandom_range(0, 63));
            sw_int    = NS'($urandom_range(0, 3));
            int_mask  = ($urandom_range(0, 3) == 0) ? NI'($urandom_range(0, 255)) : '0;
            allow_int = $urandom_range(0, 1) == 1;
            step(); step(); step();
            chk("rnd_cause", cause_ip, {hw_int, sw_int});
            intr_now = allow_int && (({hw_int, sw_int} & int_mask) != 0);
            t = blank();
            t.iaddr  = $urandom_range(0, 7) == 0;
            t.ri     = $urandom_range(0, 7) == 0;
            t.ov     = $urandom_range(0, 7) == 0;
            t.sys    = $urandom_range(0, 7) == 0;
            t.bp     = $urandom_range(0, 7) == 0;
            t.daddr  = $urandom_range(0, 5) == 0;
            t.eret   = $urandom_range(0, 3) == 0;
            t.in_ds  = $urandom_range(0, 1) == 1;
            t.mem_we = $urandom_range(0, 1) == 1;
            t.bev    = $urandom_range(0, 1) == 1;
            t.iv     = $urandom_range(0, 1) == 1;
            t.pc     = $urandom & 32'hFFFF_FFFC;
            t.vaddr  = $urandom;
            t.epc_in = $urandom;
            t.ebase  = 20'($urandom);
            t.intr   = intr_now;
            run_txn("rnd", t, $urandom_range(0, 1) == 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
